// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: pipelined ROM requester with credit-based flow control
// feeding an in-order instruction queue, with redirect flush and stale-response discard.
module if_prefetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_en_i,
  input  logic [XLEN-1:0]          jump_addr_i,
  input  logic                     hold_i,
  output logic                     rom_req_o,
  output logic [XLEN-1:0]          rom_addr_o,
  input  logic                     rom_gnt_i,
  input  logic                     rom_rvalid_i,
  input  logic [XLEN-1:0]          rom_rdata_i,
  output logic                     inst_valid_o,
  output logic [XLEN-1:0]          inst_o,
  output logic [XLEN-1:0]          inst_addr_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int QAW = $clog2(DEPTH);
  localparam int CW  = QAW + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  // Discard can accumulate across back-to-back redirects, so give it headroom.
  localparam int DW  = OW + 8;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          q_mem_q  [DEPTH];
  entry_t          q_mem_d  [DEPTH];
  logic [XLEN-1:0] af_mem_q [MAX_OUTSTANDING];
  logic [XLEN-1:0] af_mem_d [MAX_OUTSTANDING];
  logic [QAW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [FAW-1:0]  af_rptr_q, af_rptr_d, af_wptr_q, af_wptr_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [DW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_en_q;
  logic            fire, drop, acc, pop;
  logic [DW-1:0]   disc_sum;

  function automatic logic [FAW-1:0] af_inc(input logic [FAW-1:0] p);
    return (p == FAW'(MAX_OUTSTANDING - 1)) ? '0 : p + FAW'(1);
  endfunction

  always_comb begin
    q_mem_d   = q_mem_q;
    af_mem_d  = af_mem_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    af_rptr_d = af_rptr_q;
    af_wptr_d = af_wptr_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    fetch_pc_d = fetch_pc_q;
    disc_sum  = discard_q + DW'(outst_q);

    // Credit rule: in-flight plus queued never exceeds DEPTH, so a push always has room.
    rom_req_o = req_en_q && !jump_en_i
             && (int'(outst_q) < MAX_OUTSTANDING)
             && (int'(count_q) + int'(outst_q) < DEPTH);
    fire = rom_req_o && rom_gnt_i;
    drop = rom_rvalid_i && (discard_q != '0);
    acc  = rom_rvalid_i && (discard_q == '0) && (outst_q != '0);
    pop  = (count_q != '0) && !hold_i;

    if (jump_en_i) begin
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
      af_rptr_d  = '0;
      af_wptr_d  = '0;
      outst_d    = '0;
      fetch_pc_d = jump_addr_i & ~XLEN'(3);
      // Every in-flight response becomes stale; one arriving now is consumed here.
      discard_d  = (rom_rvalid_i && disc_sum != '0) ? disc_sum - DW'(1) : disc_sum;
    end else begin
      if (pop) rptr_d = rptr_q + QAW'(1);
      if (acc) begin
        q_mem_d[wptr_q] = '{inst: rom_rdata_i, pc: af_mem_q[af_rptr_q]};
        wptr_d    = wptr_q + QAW'(1);
        af_rptr_d = af_inc(af_rptr_q);
      end
      if (drop) discard_d = discard_q - DW'(1);
      if (fire) begin
        af_mem_d[af_wptr_q] = fetch_pc_q;
        af_wptr_d  = af_inc(af_wptr_q);
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      count_d = count_q + CW'(acc) - CW'(pop);
      outst_d = outst_q + OW'(fire) - OW'(acc);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_mem_q    <= '{default: '0};
      af_mem_q   <= '{default: '0};
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      af_rptr_q  <= '0;
      af_wptr_q  <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      fetch_pc_q <= RESET_PC;
      req_en_q   <= 1'b0;
    end else begin
      q_mem_q    <= q_mem_d;
      af_mem_q   <= af_mem_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      af_rptr_q  <= af_rptr_d;
      af_wptr_q  <= af_wptr_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      req_en_q   <= 1'b1;
    end
  end

  assign rom_addr_o   = fetch_pc_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? q_mem_q[rptr_q].inst : NOP;
  assign inst_addr_o  = inst_valid_o ? q_mem_q[rptr_q].pc : '0;
  assign count_o      = count_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue: queue-based reference model of fetch/queue/discard
// rules, an in-order variable-latency ROM, and directed sequences pinning key behaviours.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_i = 1'b0;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i = 1'b0;
  logic        rom_rvalid_i = 1'b0;
  logic [31:0] rom_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [2:0]  count_o;

  if_prefetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
    .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  // reference model state
  logic [31:0] m_pc;
  ent_t        m_q[$];
  logic [31:0] m_af[$];
  int          m_dis;
  bit          m_started;
  bit          m_req;

  // ROM environment: addresses the DUT was granted, answered in order
  logic [31:0] rom_q[$];
  bit          rv_real;
  bit          dut_fire;
  logic [31:0] dut_addr;

  logic [31:0] s_req, s_addr, s_valid, s_inst, s_iaddr, s_count;
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] e_inst, e_iaddr;
    bit ev;
    ev = m_q.size() > 0;
    m_req = m_started && !jump_en_i && (m_af.size() < MAXO) && (m_q.size() + m_af.size() < DEPTH);
    e_inst  = ev ? m_q[0].inst : 32'h0000_0013;
    e_iaddr = ev ? m_q[0].pc : 32'h0;
    chk("rom_req", 32'(rom_req_o), 32'(m_req));
    chk("rom_addr", rom_addr_o, m_pc);
    chk("inst_valid", 32'(inst_valid_o), 32'(ev));
    chk("inst", inst_o, e_inst);
    chk("inst_addr", inst_addr_o, e_iaddr);
    chk("count", 32'(count_o), 32'(m_q.size()));
    s_req = 32'(rom_req_o); s_addr = rom_addr_o; s_valid = 32'(inst_valid_o);
    s_inst = inst_o; s_iaddr = inst_addr_o; s_count = 32'(count_o);
    dut_fire = rom_req_o && rom_gnt_i;
    dut_addr = rom_addr_o;
  endtask

  task automatic model_update();
    int t;
    bit pop, acc;
    ent_t e;
    if (jump_en_i) begin
      t = m_dis + m_af.size();
      if (rom_rvalid_i && t > 0) t--;
      m_dis = t;
      m_q.delete();
      m_af.delete();
      m_pc = {jump_addr_i[31:2], 2'b00};
    end else begin
      pop = (m_q.size() > 0) && !hold_i;
      acc = 1'b0;
      if (rom_rvalid_i && m_dis > 0) m_dis--;
      else if (rom_rvalid_i && m_af.size() > 0) begin
        acc = 1'b1;
        e.pc = m_af.pop_front();
        e.inst = rom_rdata_i;
      end
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(e);
      if (m_req && rom_gnt_i) begin
        m_af.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    m_started = 1'b1;
  endtask

  // Called at a falling edge: drive, check, advance one rising edge, return at next falling edge.
  task automatic cycle(input bit j, input logic [31:0] ja, input bit h, input bit g,
                       input bit rv, input bit spur);
    jump_en_i = j; jump_addr_i = ja; hold_i = h; rom_gnt_i = g;
    rv_real = rv && (rom_q.size() > 0);
    if (rv_real) begin
      rom_rvalid_i = 1'b1; rom_rdata_i = hashf(rom_q[0]);
    end else begin
      rom_rvalid_i = spur; rom_rdata_i = $urandom;
    end
    #1 compare();
    @(posedge clk);
    if (rv_real) void'(rom_q.pop_front());
    if (dut_fire) rom_q.push_back(dut_addr);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; jump_en_i = 1'b0; hold_i = 1'b0; rom_gnt_i = 1'b0; rom_rvalid_i = 1'b0;
    #1;
    chk("rst rom_req", 32'(rom_req_o), 32'h0);
    chk("rst inst_valid", 32'(inst_valid_o), 32'h0);
    chk("rst inst", inst_o, 32'h0000_0013);
    chk("rst inst_addr", inst_addr_o, 32'h0);
    chk("rst count", 32'(count_o), 32'h0);
    m_pc = 32'h0; m_q.delete(); m_af.delete(); m_dis = 0; m_started = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [31:0] prev, a0, ja;
  int pg, pr, phd, pj;

  initial begin
    do_reset();

    // reset release, full-rate grant, 1-cycle response
    cycle(0, 0, 0, 1, 1, 0); chk("A req before first edge", s_req, 0);
    cycle(0, 0, 0, 1, 1, 0); chk("A first req", s_req, 1); chk("A first addr", s_addr, 32'h0);
    cycle(0, 0, 0, 1, 1, 0); chk("A valid too early", s_valid, 0);
    cycle(0, 0, 0, 1, 1, 0); chk("A valid rise", s_valid, 1); chk("A pc0", s_iaddr, 32'h0);
    chk("A inst0", s_inst, hashf(32'h0));
    cycle(0, 0, 0, 1, 1, 0); chk("A pc1", s_iaddr, 32'h4);
    cycle(0, 0, 0, 1, 1, 0); chk("A pc2", s_iaddr, 32'h8);

    // long hold saturates the queue, then drains in order without gaps
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 1, 0);
    chk("B count sat", s_count, 4); chk("B req drop", s_req, 0);
    prev = s_iaddr;
    cycle(0, 0, 0, 1, 1, 0); chk("B head kept", s_iaddr, prev);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 1, 0); chk("B in order", s_iaddr, prev + 32'd4);
      prev = prev + 32'd4;
    end

    // redirect with two requests in flight
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 32'h100, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0); chk("C flushed", s_count, 0); chk("C flushed valid", s_valid, 0);
    for (int i = 0; i < 10 && s_valid == 0; i++) cycle(0, 0, 0, 1, 1, 0);
    chk("C first after jump", s_iaddr, 32'h100);

    // redirect coinciding with the only outstanding response
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 32'h100, 0, 0, 1, 0);
    s_valid = 0;
    for (int i = 0; i < 10 && s_valid == 0; i++) cycle(0, 0, 0, 1, 1, 0);
    chk("D first after jump", s_iaddr, 32'h100);

    // grant stall: request stays stable, exactly one fires when granted
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0); a0 = s_addr; chk("E req", s_req, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0); chk("E stable addr", s_addr, a0); chk("E stable req", s_req, 1);
    end
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0); chk("E one fire", s_addr, a0 + 32'd4);
    cycle(0, 0, 0, 0, 0, 0); chk("E one fire hold", s_addr, a0 + 32'd4);

    // async reset mid-stream, stale beats afterwards
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0); chk("F stale ignored", s_count, 0);
    cycle(0, 0, 0, 1, 1, 0); chk("F restart addr", s_addr, 32'h0); chk("F restart req", s_req, 1);

    // randomized phases
    for (int ph = 0; ph < 40; ph++) begin
      pg = $urandom_range(20, 100); pr = $urandom_range(20, 100);
      phd = $urandom_range(0, 70);  pj = $urandom_range(0, 8);
      if (ph % 13 == 7) do_reset();
      for (int c = 0; c < 80; c++) begin
        case ($urandom_range(0, 2))
          0: ja = $urandom & 32'h0000_0FFC;
          1: ja = $urandom;
          default: ja = 32'hFFFF_FFF8;
        endcase
        cycle($urandom_range(0, 99) < pj, ja, $urandom_range(0, 99) < phd,
              $urandom_range(0, 99) < pg, $urandom_range(0, 99) < pr,
              $urandom_range(0, 99) < 3);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
